seq_mult_hs: RTL and testbench

// Parametrised shift-add sequential multiplier, MSB-first, one multiplier bit per cycle.

---
 rtl/seq_mult_hs.sv | 130 +++++++++++++
 tb/tb_seq_mult_hs.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_hs.sv
// seq_mult_hs: shift-add sequential multiplier, MSB-first, one multiplier bit per cycle.
// Operands are accepted on a valid/ready handshake and converted to magnitudes. The
// unsigned product is built over WIDTH cycles. The sign is applied on the final step,
// and the result is held until the consumer takes it.
//
// Handshake rules (both ports): a transfer happens on a rising edge where valid and
// ready are both 1. in_ready and out_valid depend only on the FSM state, never
// combinationally on in_valid/out_ready. A producer may drop valid without a transfer
// while ready is low. Operands need only be stable on the accept edge.
`timescale 1ns/1ps

module seq_mult_hs #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0]        CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0]   ONE_P    = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_mag_q, a_mag_d;
    logic [WIDTH-1:0]     b_mag_q, b_mag_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_next;

    // Next-state, datapath update and handshake outputs for the IDLE/BUSY/DONE FSM
    always_comb begin
        state_d   = state_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        // In signed mode the magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1) as unsigned, which still fits
        a_abs = (signed_mode && a[WIDTH-1]) ? (~a + ONE_W) : a;
        b_abs = (signed_mode && b[WIDTH-1]) ? (~b + ONE_W) : b;

        // One MSB-first partial product step; acc is double width so it cannot overflow
        addend   = b_mag_q[WIDTH-1] ? {{WIDTH{1'b0}}, a_mag_q} : '0;
        acc_next = (acc_q << 1) + addend;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_mag_d = a_abs;
                    b_mag_d = b_abs;
                    neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = CNT_INIT;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d   = acc_next;
                b_mag_d = b_mag_q << 1;
                cnt_d   = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    // Negating zero yields zero, so a zero product never becomes nonzero
                    product_d = neg_q ? (~acc_next + ONE_P) : acc_next;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_hs.sv
// Testbench for seq_mult_hs: directed spec cases with latency and hold checks,
// a reset-during-BUSY case, then 1000 random ops against an arithmetic reference.
`timescale 1ns/1ps

module tb_seq_mult_hs;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   product;

  always #5 clk = ~clk;

  seq_mult_hs #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer multiply of the operands as interpreted by the mode
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sm);
    longint xv, yv;
    logic [63:0] p;
    if (sm) begin
      xv = longint'($signed(x));
      yv = longint'($signed(y));
    end else begin
      xv = longint'(x);
      yv = longint'(y);
    end
    p = 64'(xv * yv);
    return p[2*W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready(input string tag);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // One full transaction: accept, measure latency, check result, hold in DONE, complete.
  // With poke set, in_valid stays high through BUSY and DONE to prove it is ignored.
  task automatic directed_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                             input logic sm, input logic [2*W-1:0] want,
                             input int hold, input bit poke);
    int  k;
    bit  extra;
    logic [2*W-1:0] held;
    wait_in_ready(tag);
    a = ta; b = tb_v; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid    = poke;
    a           = W'($urandom);
    b           = W'($urandom);
    signed_mode = 1'($urandom_range(0, 1));
    k = 0;
    while (!out_valid && k < 3 * W) begin
      step();
      k++;
    end
    check({tag, "/latency"}, 64'(k), 64'(W));
    check({tag, "/product"}, 64'(product), 64'(want));
    held = product;
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "/hold_product"}, 64'(product), 64'(held));
      check({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "/hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "/post_valid"}, 64'(out_valid), 64'd0);
    check({tag, "/post_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "/post_product"}, 64'(product), 64'(want));
    if (poke) begin
      extra = 1'b0;
      for (int i = 0; i < W + 3; i++) begin
        step();
        if (out_valid) extra = 1'b1;
      end
      check({tag, "/no_extra_product"}, 64'(extra), 64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int got;
    int pushed;
    int cyc;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; signed_mode = 1'b0;
    step();
    step();
    check("reset/in_ready", 64'(in_ready), 64'd1);
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/product", 64'(product), 64'd0);
    reset = 1'b0;
    step();

    directed_op("u_ff_ff",   8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, 1'b0);
    directed_op("s_m128sq",  8'h80, 8'h80, 1'b1, 16'h4000, 2, 1'b0);
    directed_op("s_m3x5",    8'hFD, 8'h05, 1'b1, 16'hFFF1, 5, 1'b1);
    directed_op("s_127xm1",  8'h7F, 8'hFF, 1'b1, 16'hFF81, 1, 1'b0);
    directed_op("s_0xm7",    8'h00, 8'hF9, 1'b1, 16'h0000, 0, 1'b0);
    directed_op("u_fd_5",    8'hFD, 8'h05, 1'b0, 16'h04F1, 0, 1'b0);
    directed_op("s_fd_5",    8'hFD, 8'h05, 1'b1, 16'hFFF1, 0, 1'b0);

    // Reset three cycles into BUSY discards the operation and clears the product
    wait_in_ready("rst_busy");
    a = 8'd9; b = 8'd11; signed_mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_busy/in_ready", 64'(in_ready), 64'd1);
    check("rst_busy/out_valid", 64'(out_valid), 64'd0);
    check("rst_busy/product", 64'(product), 64'd0);
    directed_op("after_rst_6x7", 8'd6, 8'd7, 1'b0, 16'd42, 0, 1'b0);

    // Random back-to-back traffic with random consumer backpressure
    got = 0; pushed = 0; cyc = 0;
    while (got < 1000 && cyc < 60000) begin
      in_valid    = (pushed < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      a           = W'($urandom);
      b           = W'($urandom);
      signed_mode = 1'($urandom_range(0, 1));
      out_ready   = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mul(a, b, signed_mode));
        pushed++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand/spurious_product", 64'd1, 64'd0);
        end else begin
          check("rand/product", 64'(product), 64'(exp_q.pop_front()));
          got++;
        end
      end
      step();
      cyc++;
    end
    check("rand/ops_completed", 64'(got), 64'd1000);
    check("rand/queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
